// File: rtl/iob_uart2iob_pkg.sv
// Shared definitions for the UART-to-IOb bridge: FSM states, response codes
// and command-byte field helpers.
package iob_uart2iob_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_WAIT_R,
        ST_RESP
    } state_t;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    localparam int unsigned CMD_WR_BIT = 7;

    // Bits of CMD that are neither the write flag nor a strobe bit must be zero.
    function automatic logic [7:0] cmd_rsvd_mask(input int unsigned data_b);
        logic [7:0] m;
        m = 8'h7F;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < data_b) m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/iob_uart2iob_shreg.sv
// Byte-wide shift register with byte counter: bytes enter at the top (LSB-first
// streams assemble in place) and leave from the bottom.
module iob_uart2iob_shreg #(
    parameter int unsigned W     = 32,
    parameter int unsigned OUT_W = W
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_cke,
    input  logic             i_load,
    input  logic [W-1:0]     i_ldata,
    input  logic             i_shift_in,
    input  logic [7:0]       i_byte,
    input  logic             i_shift_out,
    output logic [OUT_W-1:0] o_data,
    output logic             o_last
);

    localparam int unsigned NB    = W / 8;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_cke) begin
            if (i_load) begin
                r_data <= i_ldata;
                r_cnt  <= '0;
            end else if (i_shift_in) begin
                r_data <= (r_data >> 8) | (W'(i_byte) << (W - 8));
                r_cnt  <= r_cnt + CNT_W'(1);
            end else if (i_shift_out) begin
                r_data <= r_data >> 8;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_data = r_data[OUT_W-1:0];
    assign o_last = (r_cnt == CNT_W'(NB - 1));

endmodule

// File: rtl/iob_uart2iob.sv
// UART-to-IOb bridge: decodes CMD/ADDR/DATA frames from a UART byte stream,
// issues IOb initiator transactions and streams ACK/NAK or read data back.
module iob_uart2iob
    import iob_uart2iob_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i,
    output logic                busy_o
);

    localparam int unsigned DATA_B = DATA_W / 8;
    localparam logic [7:0]  RSVD   = cmd_rsvd_mask(DATA_B);
    localparam logic [TIMEOUT_W-1:0] T_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    state_t              r_state, w_next;
    logic                r_live;
    logic                r_write;
    logic                r_single;
    logic [DATA_B-1:0]   r_wstrb;
    logic [TIMEOUT_W-1:0] r_timer;

    logic                w_rx_fire, w_tx_fire, w_frame_start, w_timeout;
    logic                w_addr_last, w_wdata_last, w_resp_last;
    logic                w_resp_load, w_resp_rd;
    logic [DATA_W-1:0]   w_resp_ldata;

    assign w_rx_fire     = rx_valid_i & rx_ready_o;
    assign w_tx_fire     = tx_valid_o & tx_ready_i;
    assign w_frame_start = (r_state == ST_IDLE) & w_rx_fire;
    assign w_timeout     = (r_timer == T_LAST);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) r_state <= ST_IDLE;
        else if (cke_i) r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_resp_load  = 1'b0;
        w_resp_rd    = 1'b0;
        w_resp_ldata = '0;
        unique case (r_state)
            ST_IDLE: if (w_rx_fire) begin
                if ((rx_data_i & RSVD) != 8'h00) begin
                    w_next       = ST_RESP;
                    w_resp_load  = 1'b1;
                    w_resp_ldata = DATA_W'(RESP_NAK);
                end else begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: if (w_rx_fire && w_addr_last) w_next = r_write ? ST_DATA : ST_REQ;
            ST_DATA: if (w_rx_fire && w_wdata_last) begin
                if (r_wstrb == '0) begin
                    w_next       = ST_RESP;
                    w_resp_load  = 1'b1;
                    w_resp_ldata = DATA_W'(RESP_ACK);
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (iob_ready_i) begin
                    if (r_write) begin
                        w_next       = ST_RESP;
                        w_resp_load  = 1'b1;
                        w_resp_ldata = DATA_W'(RESP_ACK);
                    end else if (iob_rvalid_i) begin
                        w_next       = ST_RESP;
                        w_resp_load  = 1'b1;
                        w_resp_rd    = 1'b1;
                        w_resp_ldata = iob_rdata_i;
                    end else begin
                        w_next = ST_WAIT_R;
                    end
                end else if (w_timeout) begin
                    w_next       = ST_RESP;
                    w_resp_load  = 1'b1;
                    w_resp_ldata = DATA_W'(RESP_NAK);
                end
            end
            ST_WAIT_R: begin
                if (iob_rvalid_i) begin
                    w_next       = ST_RESP;
                    w_resp_load  = 1'b1;
                    w_resp_rd    = 1'b1;
                    w_resp_ldata = iob_rdata_i;
                end else if (w_timeout) begin
                    w_next       = ST_RESP;
                    w_resp_load  = 1'b1;
                    w_resp_ldata = DATA_W'(RESP_NAK);
                end
            end
            ST_RESP: if (w_tx_fire && (r_single || w_resp_last)) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // rx_ready_o is gated by r_live so that every output reads 0 while in reset.
    always_comb begin
        rx_ready_o   = r_live & ((r_state == ST_IDLE) | (r_state == ST_ADDR) |
                                 (r_state == ST_DATA));
        tx_valid_o   = (r_state == ST_RESP);
        iob_avalid_o = (r_state == ST_REQ);
        busy_o       = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_live   <= 1'b0;
            r_write  <= 1'b0;
            r_wstrb  <= '0;
            r_single <= 1'b0;
            r_timer  <= '0;
        end else if (cke_i) begin
            r_live <= 1'b1;
            if (w_frame_start) begin
                r_write <= rx_data_i[CMD_WR_BIT];
                r_wstrb <= rx_data_i[CMD_WR_BIT] ? rx_data_i[DATA_B-1:0] : '0;
            end
            if (w_resp_load) r_single <= ~w_resp_rd;
            if ((w_next == ST_REQ) && (r_state != ST_REQ)) begin
                r_timer <= '0;
            end else if (((r_state == ST_REQ) || (r_state == ST_WAIT_R)) && (r_timer != '1)) begin
                r_timer <= r_timer + TIMEOUT_W'(1);
            end
        end
    end

    iob_uart2iob_shreg #(.W(ADDR_W)) u_addr (
        .i_clk       (clk_i),
        .i_arst_n    (arst_n_i),
        .i_cke       (cke_i),
        .i_load      (w_frame_start),
        .i_ldata     ('0),
        .i_shift_in  (w_rx_fire && (r_state == ST_ADDR)),
        .i_byte      (rx_data_i),
        .i_shift_out (1'b0),
        .o_data      (iob_addr_o),
        .o_last      (w_addr_last)
    );

    iob_uart2iob_shreg #(.W(DATA_W)) u_wdata (
        .i_clk       (clk_i),
        .i_arst_n    (arst_n_i),
        .i_cke       (cke_i),
        .i_load      (w_frame_start),
        .i_ldata     ('0),
        .i_shift_in  (w_rx_fire && (r_state == ST_DATA)),
        .i_byte      (rx_data_i),
        .i_shift_out (1'b0),
        .o_data      (iob_wdata_o),
        .o_last      (w_wdata_last)
    );

    iob_uart2iob_shreg #(.W(DATA_W), .OUT_W(8)) u_resp (
        .i_clk       (clk_i),
        .i_arst_n    (arst_n_i),
        .i_cke       (cke_i),
        .i_load      (w_resp_load),
        .i_ldata     (w_resp_ldata),
        .i_shift_in  (1'b0),
        .i_byte      (8'h00),
        .i_shift_out (w_tx_fire),
        .o_data      (tx_data_o),
        .o_last      (w_resp_last)
    );

    assign iob_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_iob_uart2iob.sv
// Directed self-checking bench for iob_uart2iob (32-bit addr/data, 4-bit timeout).
module tb_iob_uart2iob;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        iob_avalid_o;
    logic [31:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;
    logic        iob_ready_i;
    logic        busy_o;

    int n_checks = 0;
    int n_err    = 0;

    iob_uart2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .cke_i        (cke_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .iob_avalid_o (iob_avalid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rvalid_i (iob_rvalid_i),
        .iob_rdata_i  (iob_rdata_i),
        .iob_ready_i  (iob_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!acc && n < 50) begin
            acc = rx_ready_o;
            tick();
            n++;
        end
        rx_valid_i = 1'b0;
        if (!acc) chk("rx_accept_wait", rx_ready_o, 1);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        b = 8'hxx;
        tx_ready_i = 1'b1;
        while (!got && n < 50) begin
            if (tx_valid_o) begin
                got = 1'b1;
                b   = tx_data_o;
            end
            tick();
            n++;
        end
        tx_ready_i = 1'b0;
        if (!got) chk("tx_valid_wait", tx_valid_o, 1);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic send_write(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic recv_word(input string tag, input logic [31:0] exp_word);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            chk(tag, b, exp_word[8*i +: 8]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, rx_ready_o, 0);
        chk({tag, "_tx_valid"}, tx_valid_o, 0);
        chk({tag, "_tx_data"},  tx_data_o, 0);
        chk({tag, "_avalid"},   iob_avalid_o, 0);
        chk({tag, "_addr"},     iob_addr_o, 0);
        chk({tag, "_wdata"},    iob_wdata_o, 0);
        chk({tag, "_wstrb"},    iob_wstrb_o, 0);
        chk({tag, "_busy"},     busy_o, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         n;

        arst_n_i = 1'b0; cke_i = 1'b1;
        rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        tick(); tick();
        chk_all_zero("reset");
        arst_n_i = 1'b1;
        tick();
        chk("idle_rx_ready", rx_ready_o, 1);

        // Write 0x86 to 0x100 with data 0xDEADBEEF, ready after 2 cycles
        send_byte(8'h86);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("wr_avalid", iob_avalid_o, 1);
        chk("wr_addr", iob_addr_o, 32'h0000_0100);
        chk("wr_wdata", iob_wdata_o, 32'hDEAD_BEEF);
        chk("wr_wstrb", iob_wstrb_o, 4'h6);
        chk("wr_rx_ready_req", rx_ready_o, 0);
        repeat (2) begin
            tick();
            chk("wr_avalid_hold", iob_avalid_o, 1);
        end
        iob_ready_i = 1'b1;
        tick();
        iob_ready_i = 1'b0;
        chk("wr_avalid_drop", iob_avalid_o, 0);
        chk("wr_ack_valid", tx_valid_o, 1);
        chk("wr_ack_data", tx_data_o, 8'h06);

        cke_i = 1'b0; tx_ready_i = 1'b1;
        repeat (3) tick();
        chk("cke_tx_valid_hold", tx_valid_o, 1);
        chk("cke_busy_hold", busy_o, 1);
        tx_ready_i = 1'b0; cke_i = 1'b1;
        recv_byte(b);
        chk("wr_ack_byte", b, 8'h06);
        chk("wr_idle", busy_o, 0);

        // Read 0x4, rvalid one cycle after ready
        send_read(32'h0000_0004);
        chk("rd_avalid", iob_avalid_o, 1);
        chk("rd_addr", iob_addr_o, 32'h0000_0004);
        chk("rd_wstrb", iob_wstrb_o, 4'h0);
        iob_ready_i = 1'b1;
        tick();
        iob_ready_i = 1'b0;
        chk("rd_wait_avalid", iob_avalid_o, 0);
        chk("rd_wait_tx_valid", tx_valid_o, 0);
        chk("rd_wait_busy", busy_o, 1);
        iob_rvalid_i = 1'b1; iob_rdata_i = 32'h1234_5678;
        tick();
        iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        chk("rd_first_valid", tx_valid_o, 1);
        chk("rd_first_data", tx_data_o, 8'h78);
        recv_word("rd_bytes", 32'h1234_5678);
        chk("rd_idle", busy_o, 0);

        // Reserved CMD bit set -> NAK, no bus transaction
        send_byte(8'h40);
        chk("bad_tx_valid", tx_valid_o, 1);
        chk("bad_tx_data", tx_data_o, 8'h15);
        chk("bad_avalid", iob_avalid_o, 0);
        recv_byte(b);
        chk("bad_nak_byte", b, 8'h15);

        // Next frame decodes normally; ready and rvalid in the same cycle
        send_read(32'h0000_0008);
        chk("rd2_avalid", iob_avalid_o, 1);
        chk("rd2_addr", iob_addr_o, 32'h0000_0008);
        iob_ready_i = 1'b1; iob_rvalid_i = 1'b1; iob_rdata_i = 32'hA1B2_C3D4;
        tick();
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        chk("rd2_avalid_drop", iob_avalid_o, 0);
        chk("rd2_tx_valid", tx_valid_o, 1);
        recv_word("rd2_bytes", 32'hA1B2_C3D4);

        // Write with zero strobe: ACK without a bus transaction
        send_write(8'h80, 32'h0000_000C, 32'h8877_6655);
        chk("wz_avalid", iob_avalid_o, 0);
        chk("wz_tx_valid", tx_valid_o, 1);
        chk("wz_tx_data", tx_data_o, 8'h06);
        recv_byte(b);
        chk("wz_ack_byte", b, 8'h06);

        // Timeout: ready never asserted
        send_read(32'h0000_0010);
        n = 0;
        while (iob_avalid_o && n < 40) begin
            n++;
            tick();
        end
        chk("to_avalid_cycles", n, 15);
        chk("to_tx_valid", tx_valid_o, 1);
        chk("to_tx_data", tx_data_o, 8'h15);
        recv_byte(b);
        chk("to_nak_byte", b, 8'h15);
        iob_rvalid_i = 1'b1; iob_rdata_i = 32'hFFFF_FFFF;
        tick();
        iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        chk("late_rvalid_busy", busy_o, 0);
        chk("late_rvalid_tx_valid", tx_valid_o, 0);

        // tx back-pressure during a read response while the host pushes a byte
        send_read(32'h0000_0020);
        iob_ready_i = 1'b1;
        tick();
        iob_ready_i = 1'b0;
        iob_rvalid_i = 1'b1; iob_rdata_i = 32'hCAFE_F00D;
        tick();
        iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        rx_valid_i = 1'b1; rx_data_i = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("bp_tx_data", tx_data_o, 8'h0D);
            chk("bp_tx_valid", tx_valid_o, 1);
            chk("bp_rx_ready", rx_ready_o, 0);
            tick();
        end
        recv_word("bp_bytes", 32'hCAFE_F00D);
        send_byte(8'h00);
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("bp_next_avalid", iob_avalid_o, 1);
        chk("bp_next_addr", iob_addr_o, 32'h0000_0030);
        iob_ready_i = 1'b1; iob_rvalid_i = 1'b1; iob_rdata_i = 32'h5A5A_A5A5;
        tick();
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        recv_word("bp_next_bytes", 32'h5A5A_A5A5);

        // Reset in the middle of the DATA phase
        send_byte(8'h8F);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        chk("mid_busy", busy_o, 1);
        arst_n_i = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk_i);
        arst_n_i = 1'b1;
        send_write(8'h8F, 32'h0000_0044, 32'h4433_2211);
        chk("fresh_avalid", iob_avalid_o, 1);
        chk("fresh_addr", iob_addr_o, 32'h0000_0044);
        chk("fresh_wdata", iob_wdata_o, 32'h4433_2211);
        chk("fresh_wstrb", iob_wstrb_o, 4'hF);
        iob_ready_i = 1'b1;
        tick();
        iob_ready_i = 1'b0;
        recv_byte(b);
        chk("fresh_ack_byte", b, 8'h06);
        chk("fresh_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
